// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and parity-mode constants for the rx/tx blocks.
package uart_pkg;
    typedef enum logic [5:0] {
        IDLE      = 6'b000001,
        START     = 6'b000010,
        DATA      = 6'b000100,
        PARITY    = 6'b001000,
        STOP      = 6'b010000,
        WAIT_HIGH = 6'b100000
    } state_t;
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous single-bit input, with selectable reset value.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_q;
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_meta <= RST_VAL;
            r_q    <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end
    assign o_q = r_q;
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with majority voting, runtime parity mode,
// framing/break detection and false-start rejection.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_STOP = 1,
    parameter int OVS     = 16,
    parameter int NB_CNT  = $clog2(OVS)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_rx,
    input  logic [1:0]         i_parity_mode,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_valid,
    output logic               o_parity_err,
    output logic               o_frame_err,
    output logic               o_break
);
    localparam int NB_IDX = $clog2(NB_DATA);
    localparam logic [NB_CNT-1:0] C_V0  = NB_CNT'(OVS/2-1);
    localparam logic [NB_CNT-1:0] C_V1  = NB_CNT'(OVS/2);
    localparam logic [NB_CNT-1:0] C_DEC = NB_CNT'(OVS/2+1);
    localparam logic [NB_CNT-1:0] C_END = NB_CNT'(OVS-1);

    state_t               r_state, w_next;
    logic [NB_CNT-1:0]    r_cnt;
    logic [NB_IDX-1:0]    r_idx;
    logic                 r_stop_idx;
    logic [1:0]           r_par_mode;
    logic [1:0]           r_votes;
    logic [NB_DATA-1:0]   r_shreg;
    logic                 r_par_err;
    logic                 r_frm_err;
    logic                 r_par_bit;
    logic                 r_stop0;
    logic [NB_DATA-1:0]   r_data;
    logic                 r_valid;
    logic                 r_perr_o;
    logic                 r_ferr_o;
    logic                 r_brk_o;
    logic                 w_rx_s;
    logic                 w_vote;
    logic                 w_dec;
    logic                 w_end;
    logic                 w_par_en;
    logic                 w_last_stop;
    logic                 w_start;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_d    (i_rx),
        .o_q    (w_rx_s)
    );

    // third sample is the live line value on the decision tick
    assign w_vote      = (r_votes[0] & r_votes[1]) | (w_rx_s & (r_votes[0] | r_votes[1]));
    assign w_dec       = i_tick && (r_cnt == C_DEC);
    assign w_end       = i_tick && (r_cnt == C_END);
    assign w_par_en    = (r_par_mode == PAR_EVEN) || (r_par_mode == PAR_ODD);
    assign w_last_stop = (r_stop_idx == 1'(NB_STOP-1));
    assign w_start     = (r_state == IDLE) && !w_rx_s;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      w_next = w_rx_s ? IDLE : START;
            START:     w_next = (w_dec && w_vote) ? IDLE : (w_end ? DATA : START);
            DATA:      if (w_end && r_idx == NB_IDX'(NB_DATA-1)) w_next = w_par_en ? PARITY : STOP;
            PARITY:    w_next = w_end ? STOP : PARITY;
            STOP:      if (w_dec && w_last_stop) w_next = w_rx_s ? IDLE : WAIT_HIGH;
            WAIT_HIGH: w_next = w_rx_s ? IDLE : WAIT_HIGH;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_stop_idx <= 1'b0;
            r_par_mode <= PAR_NONE;
            r_votes    <= 2'b00;
            r_shreg    <= '0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
            r_par_bit  <= 1'b0;
            r_stop0    <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_perr_o   <= 1'b0;
            r_ferr_o   <= 1'b0;
            r_brk_o    <= 1'b0;
        end else begin
            r_valid  <= 1'b0;
            r_perr_o <= 1'b0;
            r_ferr_o <= 1'b0;
            r_brk_o  <= 1'b0;
            if (r_state == IDLE || r_state == WAIT_HIGH) r_cnt <= '0;
            else if (i_tick) r_cnt <= (r_cnt == C_END) ? '0 : r_cnt + 1'b1;
            if (i_tick && r_cnt == C_V0) r_votes[0] <= w_rx_s;
            if (i_tick && r_cnt == C_V1) r_votes[1] <= w_rx_s;
            if (w_start) begin
                r_par_mode <= i_parity_mode;
                r_idx      <= '0;
                r_stop_idx <= 1'b0;
                r_par_err  <= 1'b0;
                r_frm_err  <= 1'b0;
                r_par_bit  <= 1'b0;
                r_stop0    <= 1'b0;
            end
            if (r_state == DATA && w_dec) r_shreg <= {w_vote, r_shreg[NB_DATA-1:1]};
            if (r_state == DATA && w_end) r_idx <= r_idx + 1'b1;
            if (r_state == PARITY && w_dec) begin
                r_par_err <= ((^r_shreg) ^ w_vote) != r_par_mode[1];
                r_par_bit <= w_vote;
            end
            if (r_state == STOP && w_dec) begin
                if (!w_vote) r_frm_err <= 1'b1;
                if (!r_stop_idx) r_stop0 <= w_vote;
                if (w_last_stop) begin
                    r_valid  <= 1'b1;
                    r_data   <= r_shreg;
                    r_perr_o <= r_par_err;
                    r_ferr_o <= r_frm_err | ~w_vote;
                    r_brk_o  <= (r_shreg == '0) && !r_par_bit && !(r_stop_idx ? r_stop0 : w_vote);
                end
            end
            if (r_state == STOP && w_end) r_stop_idx <= 1'b1;
        end
    end

    assign o_data       = r_data;
    assign o_valid      = r_valid;
    assign o_parity_err = r_perr_o;
    assign o_frame_err  = r_ferr_o;
    assign o_break      = r_brk_o;
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed frames against a default receiver and a 7-bit/2-stop/OVS=8 receiver.
module tb_uart_rx_param;
    import uart_pkg::*;
    localparam int TDIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       rx = 1'b1;
    logic       rx7 = 1'b1;
    logic [1:0] pm = 2'b00;
    logic [1:0] pm7 = 2'b00;
    logic [7:0] d8;
    logic [6:0] d7;
    logic       v8, pe8, fe8, bk8, v7, pe7, fe7, bk7;

    int total = 0, bad = 0;
    int cyc = 0, edge_cyc = 0;
    int nv = 0, vcyc = 0, nv7 = 0, stray = 0;
    logic [7:0] vd;
    logic [6:0] vd7;
    logic vp, vf, vb, vf7, vb7;

    uart_rx_param dut (
        .i_clk(clk), .i_reset(rst), .i_tick(tick), .i_rx(rx), .i_parity_mode(pm),
        .o_data(d8), .o_valid(v8), .o_parity_err(pe8), .o_frame_err(fe8), .o_break(bk8)
    );

    uart_rx_param #(.NB_DATA(7), .NB_STOP(2), .OVS(8)) dut7 (
        .i_clk(clk), .i_reset(rst), .i_tick(tick), .i_rx(rx7), .i_parity_mode(pm7),
        .o_data(d7), .o_valid(v7), .o_parity_err(pe7), .o_frame_err(fe7), .o_break(bk7)
    );

    always #5 clk = ~clk;

    initial begin
        int t = 0;
        forever begin
            @(negedge clk);
            tick = (t == TDIV-1);
            t = (t + 1) % TDIV;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (v8) begin
            nv++; vd = d8; vp = pe8; vf = fe8; vb = bk8; vcyc = cyc;
        end else if (pe8 | fe8 | bk8) stray++;
        if (v7) begin
            nv7++; vd7 = d7; vf7 = fe7; vb7 = bk7;
        end else if (pe7 | fe7 | bk7) stray++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v);
        if (sel == 0) rx = v; else rx7 = v;
    endtask

    task automatic hold(input int sel, input logic v, input int ovs);
        drive(sel, v);
        repeat (ovs*TDIV) @(negedge clk);
    endtask

    // gb: index of a data bit that gets a one-tick low glitch at mid-bit (-1 for none)
    task automatic send(input int sel, input logic [8:0] data, input int nb, input bit par_en,
                        input logic par_bit, input logic [1:0] stops, input int nstop,
                        input int ovs, input int gb);
        if (sel == 0) edge_cyc = cyc;
        hold(sel, 1'b0, ovs);
        for (int i = 0; i < nb; i++) begin
            if (i == gb) begin
                drive(sel, data[i]);
                repeat (ovs*TDIV/2) @(negedge clk);
                drive(sel, 1'b0);
                repeat (TDIV) @(negedge clk);
                drive(sel, data[i]);
                repeat (ovs*TDIV/2 - TDIV) @(negedge clk);
            end else hold(sel, data[i], ovs);
        end
        if (par_en) hold(sel, par_bit, ovs);
        for (int i = 0; i < nstop; i++) hold(sel, stops[i], ovs);
        hold(sel, 1'b1, 2*ovs);
    endtask

    task automatic check_frame(input string tag, input int n0, input logic [7:0] data,
                               input logic pe, input logic fe, input logic bk);
        check({tag, "_cnt"}, nv, n0 + 1);
        check({tag, "_data"}, vd, data);
        check({tag, "_perr"}, vp, pe);
        check({tag, "_ferr"}, vf, fe);
        check({tag, "_brk"}, vb, bk);
    endtask

    initial begin
        int n0, lat, exp_lat;
        repeat (3) @(negedge clk);
        check("rst_data", d8, 0);
        check("rst_valid", v8, 0);
        check("rst_flags", {pe8, fe8, bk8}, 0);
        check("rst_data7", d7, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // start period + 8 data periods + half stop period + 2 ticks, plus the synchroniser
        n0 = nv;
        send(0, 9'h0A5, 8, 0, 0, 2'b11, 1, 16, -1);
        check_frame("a5", n0, 8'hA5, 0, 0, 0);
        lat = vcyc - edge_cyc;
        exp_lat = 2 + (9*16 + 8 + 2) * TDIV;
        check("a5_latency", (lat >= exp_lat - TDIV) && (lat <= exp_lat + TDIV), 1);

        pm = PAR_EVEN;
        n0 = nv; send(0, 9'h007, 8, 1, 0, 2'b11, 1, 16, -1);
        check_frame("even_p0", n0, 8'h07, 1, 0, 0);
        n0 = nv; send(0, 9'h007, 8, 1, 1, 2'b11, 1, 16, -1);
        check_frame("even_p1", n0, 8'h07, 0, 0, 0);
        pm = PAR_ODD;
        n0 = nv; send(0, 9'h007, 8, 1, 0, 2'b11, 1, 16, -1);
        check_frame("odd_p0", n0, 8'h07, 0, 0, 0);

        // mode is latched at the start edge; changing it mid-frame must not matter
        pm = PAR_NONE;
        n0 = nv;
        fork
            send(0, 9'h0C3, 8, 0, 0, 2'b11, 1, 16, -1);
            begin repeat (16*TDIV*3) @(negedge clk); pm = PAR_EVEN; end
        join
        check_frame("mode_latch", n0, 8'hC3, 0, 0, 0);
        pm = PAR_NONE;

        n0 = nv;
        hold(0, 1'b0, 4);
        hold(0, 1'b1, 32);
        check("glitch_nov", nv, n0);
        check("glitch_idle", 32'(dut.r_state), 32'(IDLE));
        n0 = nv; send(0, 9'h0FF, 8, 0, 0, 2'b11, 1, 16, 3);
        check_frame("vote_ff", n0, 8'hFF, 0, 0, 0);

        n0 = nv; send(0, 9'h03C, 8, 0, 0, 2'b00, 1, 16, -1);
        check_frame("stop_low", n0, 8'h3C, 0, 1, 0);

        n0 = nv;
        hold(0, 1'b0, 20*16);
        check_frame("break", n0, 8'h00, 0, 1, 1);
        hold(0, 1'b1, 3*16);
        check("break_once", nv, n0 + 1);
        check("break_idle", 32'(dut.r_state), 32'(IDLE));

        n0 = nv7;
        send(1, 9'h055, 7, 0, 0, 2'b01, 2, 8, -1);
        check("n7_cnt", nv7, n0 + 1);
        check("n7_data", vd7, 7'h55);
        check("n7_ferr", vf7, 1);
        check("n7_brk", vb7, 0);
        n0 = nv7;
        send(1, 9'h02A, 7, 0, 0, 2'b11, 2, 8, -1);
        check("n7_ok_data", vd7, 7'h2A);
        check("n7_ok_ferr", {nv7 - n0 == 1, vf7}, 2'b10);

        n0 = nv;
        hold(0, 1'b0, 16);
        hold(0, 1'b0, 16);
        hold(0, 1'b1, 16);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_data", d8, 0);
        check("mid_rst_outs", {v8, pe8, fe8, bk8}, 0);
        rx = 1'b1;
        rst = 1'b0;
        repeat (12*16*TDIV) @(negedge clk);
        check("abort_nov", nv, n0);
        n0 = nv; send(0, 9'h081, 8, 0, 0, 2'b11, 1, 16, -1);
        check_frame("after_rst", n0, 8'h81, 0, 0, 0);

        check("stray_flags", stray, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
